// File: rtl/axi_chk_pkg.sv
// Shared types and constants for the AXI-Lite read-channel protocol checker:
// per-channel FSM states, error codes and the flag bit positions inside a channel slice.
package axi_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STALL   = 2'd1,
      ST_TIMEOUT = 2'd2
   } ch_state_e;

   typedef enum logic [2:0] {
      ERR_NONE           = 3'd0,
      ERR_RDATA_STABLE   = 3'd1,
      ERR_RVALID_STABLE  = 3'd2,
      ERR_RVALID_RESET   = 3'd3,
      ERR_RREADY_TIMEOUT = 3'd4,
      ERR_R_NO_AR        = 3'd5,
      ERR_AR_OVERFLOW    = 3'd6
   } err_code_e;

   localparam int NUM_ERR = 6;

   // Flag bit k-1 of a channel slice holds error code k.
   localparam int FLAG_RDATA_STABLE   = 0;
   localparam int FLAG_RVALID_STABLE  = 1;
   localparam int FLAG_RVALID_RESET   = 2;
   localparam int FLAG_RREADY_TIMEOUT = 3;
   localparam int FLAG_R_NO_AR        = 4;
   localparam int FLAG_AR_OVERFLOW    = 5;

   function automatic logic [2:0] flag_code(input int idx);
      return 3'(idx + 1);
   endfunction

endpackage

// File: rtl/axi_rd_ch_checker.sv
// One AXI-Lite read channel: stall FSM with RDATA/RVALID stability and RREADY timeout
// checks, plus an outstanding-AR counter. err_o flags violations seen at the coming edge.
module axi_rd_ch_checker
   import axi_chk_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_WAIT        = 5,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  arvalid_i,
   input  logic                  arready_i,
   input  logic                  rvalid_i,
   input  logic                  rready_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic [NUM_ERR-1:0]    err_o,
   output ch_state_e             state_o
);

   localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
   localparam logic [3:0] OUT_MAX  = 4'(MAX_OUTSTANDING);

   ch_state_e             state_q, state_d;
   logic [7:0]            wait_q, wait_d, wait_inc;
   logic [DATA_WIDTH-1:0] cap_q, cap_d;
   logic [3:0]            out_q, out_d;
   logic                  first_q;
   logic                  stalled, ar_hs, r_hs, no_ar, overflow;

   assign stalled  = rvalid_i & ~rready_i;
   assign ar_hs    = arvalid_i & arready_i;
   assign r_hs     = rvalid_i & rready_i;
   assign wait_inc = wait_q + 8'd1;
   assign state_o  = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Leaving a stall happens either by handshake or by RVALID dropping (!stalled covers both).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (stalled) state_d = ST_STALL;
         ST_STALL: begin
            if (!stalled)                  state_d = ST_IDLE;
            else if (wait_inc == WAIT_LIM) state_d = ST_TIMEOUT;
         end
         ST_TIMEOUT: if (!stalled) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_o = '0;
      if (state_q != ST_IDLE) begin
         if (!rvalid_i)               err_o[FLAG_RVALID_STABLE] = 1'b1;
         else if (rdata_i != cap_q)   err_o[FLAG_RDATA_STABLE]  = 1'b1;
      end
      if (state_q == ST_STALL && stalled && wait_inc == WAIT_LIM)
         err_o[FLAG_RREADY_TIMEOUT] = 1'b1;
      if (first_q && rvalid_i) err_o[FLAG_RVALID_RESET] = 1'b1;
      err_o[FLAG_R_NO_AR]     = no_ar;
      err_o[FLAG_AR_OVERFLOW] = overflow;
   end

   // A changed RDATA is re-captured so one change reports once, not every cycle.
   always_comb begin
      wait_d = wait_q;
      cap_d  = cap_q;
      if (state_q == ST_IDLE && stalled) begin
         wait_d = '0;
         cap_d  = rdata_i;
      end else if (state_q == ST_STALL && stalled) begin
         wait_d = wait_inc;
      end
      if (state_q != ST_IDLE && rvalid_i && rdata_i != cap_q) cap_d = rdata_i;
   end

   always_comb begin
      out_d    = out_q;
      no_ar    = 1'b0;
      overflow = 1'b0;
      if (ar_hs && !r_hs) begin
         if (out_q == OUT_MAX) overflow = 1'b1;
         else                  out_d    = out_q + 4'd1;
      end else if (r_hs && !ar_hs) begin
         if (out_q == 4'd0) no_ar = 1'b1;
         else               out_d = out_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_q  <= '0;
         cap_q   <= '0;
         out_q   <= '0;
         first_q <= 1'b1;
      end else begin
         wait_q  <= wait_d;
         cap_q   <= cap_d;
         out_q   <= out_d;
         first_q <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_rd_checker.sv
// Multi-channel AXI-Lite read checker: one axi_rd_ch_checker per channel, with sticky
// flag aggregation, a saturating error-event counter and first-error capture.
module axi_rd_checker
   import axi_chk_pkg::*;
#(
   parameter int  NUM_CH          = 4,
   parameter int  DATA_WIDTH      = 32,
   parameter int  MAX_WAIT        = 5,
   parameter int  MAX_OUTSTANDING = 4,
   parameter int  CNT_WIDTH       = 16,
   localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         AXI_ACLK,
   input  logic                         AXI_ARESETN,
   input  logic [NUM_CH-1:0]            AXI_ARVALID,
   input  logic [NUM_CH-1:0]            AXI_ARREADY,
   input  logic [NUM_CH-1:0]            AXI_RVALID,
   input  logic [NUM_CH-1:0]            AXI_RREADY,
   input  logic [NUM_CH*DATA_WIDTH-1:0] AXI_RDATA,
   input  logic                         ERR_CLEAR,
   output logic [NUM_CH*NUM_ERR-1:0]    ERR_FLAGS,
   output logic                         ERR_IRQ,
   output logic [CNT_WIDTH-1:0]         ERR_COUNT,
   output logic                         FIRST_ERR_VALID,
   output logic [CH_W-1:0]              FIRST_ERR_CH,
   output logic [2:0]                   FIRST_ERR_CODE,
   output logic [2*NUM_CH-1:0]          DBG_CH_STATE
);

   logic [NUM_CH*NUM_ERR-1:0] ev, flags_q, flags_d;
   logic [CNT_WIDTH-1:0]      count_q, count_d;
   logic [CNT_WIDTH:0]        sum;
   logic                      fv_q, fv_d, fv_base;
   logic [CH_W-1:0]           fch_q, fch_d;
   logic [2:0]                fcode_q, fcode_d;
   ch_state_e                 ch_state [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axi_rd_ch_checker #(
         .DATA_WIDTH      (DATA_WIDTH),
         .MAX_WAIT        (MAX_WAIT),
         .MAX_OUTSTANDING (MAX_OUTSTANDING)
      ) u_ch (
         .clk_i     (AXI_ACLK),
         .rst_ni    (AXI_ARESETN),
         .arvalid_i (AXI_ARVALID[g]),
         .arready_i (AXI_ARREADY[g]),
         .rvalid_i  (AXI_RVALID[g]),
         .rready_i  (AXI_RREADY[g]),
         .rdata_i   (AXI_RDATA[g*DATA_WIDTH +: DATA_WIDTH]),
         .err_o     (ev[g*NUM_ERR +: NUM_ERR]),
         .state_o   (ch_state[g])
      );
      assign DBG_CH_STATE[g*2 +: 2] = ch_state[g];
   end

   // Clear is applied first and same-cycle events are then layered on top.
   always_comb begin
      fv_base = ERR_CLEAR ? 1'b0 : fv_q;
      flags_d = (ERR_CLEAR ? '0 : flags_q) | ev;
      sum     = {1'b0, (ERR_CLEAR ? '0 : count_q)};
      for (int i = 0; i < NUM_CH*NUM_ERR; i++) sum = sum + {{CNT_WIDTH{1'b0}}, ev[i]};
      count_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      fv_d    = fv_base;
      fch_d   = ERR_CLEAR ? '0 : fch_q;
      fcode_d = ERR_CLEAR ? '0 : fcode_q;
      if (!fv_base && (|ev)) begin
         fv_d = 1'b1;
         // Scan high to low so the lowest channel, then lowest code, is written last.
         for (int c = NUM_CH-1; c >= 0; c--) begin
            for (int k = NUM_ERR-1; k >= 0; k--) begin
               if (ev[c*NUM_ERR + k]) begin
                  fch_d   = CH_W'(c);
                  fcode_d = flag_code(k);
               end
            end
         end
      end
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         flags_q <= '0;
         count_q <= '0;
         fv_q    <= 1'b0;
         fch_q   <= '0;
         fcode_q <= '0;
      end else begin
         flags_q <= flags_d;
         count_q <= count_d;
         fv_q    <= fv_d;
         fch_q   <= fch_d;
         fcode_q <= fcode_d;
      end
   end

   assign ERR_FLAGS       = flags_q;
   assign ERR_IRQ         = |flags_q;
   assign ERR_COUNT       = count_q;
   assign FIRST_ERR_VALID = fv_q;
   assign FIRST_ERR_CH    = fch_q;
   assign FIRST_ERR_CODE  = fcode_q;

endmodule

// File: tb/tb_axi_rd_checker.sv
// Directed bench for axi_rd_checker with default parameters (4 channels, MAX_WAIT 5,
// MAX_OUTSTANDING 4); expected values are hand-derived constants.
module tb_axi_rd_checker;

   logic         clk;
   logic         rst_n;
   logic [3:0]   arvalid, arready, rvalid, rready;
   logic [127:0] rdata;
   logic         err_clear;
   logic [23:0]  err_flags;
   logic         err_irq;
   logic [15:0]  err_count;
   logic         first_valid;
   logic [1:0]   first_ch;
   logic [2:0]   first_code;
   logic [7:0]   dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   axi_rd_checker dut (
      .AXI_ACLK        (clk),
      .AXI_ARESETN     (rst_n),
      .AXI_ARVALID     (arvalid),
      .AXI_ARREADY     (arready),
      .AXI_RVALID      (rvalid),
      .AXI_RREADY      (rready),
      .AXI_RDATA       (rdata),
      .ERR_CLEAR       (err_clear),
      .ERR_FLAGS       (err_flags),
      .ERR_IRQ         (err_irq),
      .ERR_COUNT       (err_count),
      .FIRST_ERR_VALID (first_valid),
      .FIRST_ERR_CH    (first_ch),
      .FIRST_ERR_CODE  (first_code),
      .DBG_CH_STATE    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rdata(input int ch, input logic [31:0] v);
      rdata[ch*32 +: 32] = v;
   endtask

   task automatic clear_pulse();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      arvalid   = '0;
      arready   = '0;
      rvalid    = '0;
      rready    = '0;
      rdata     = '0;
      err_clear = 1'b0;
      tick();
      tick();
      chk("reset_flags", 64'(err_flags), 64'h0);
      chk("reset_count", 64'(err_count), 64'h0);
      chk("reset_irq", 64'(err_irq), 64'h0);
      chk("reset_first_valid", 64'(first_valid), 64'h0);
      chk("reset_state", 64'(dbg_state), 64'h0);
      rst_n = 1'b1;

      // ch0 clean stall of 3 cycles with constant data
      arvalid[0] = 1'b1; arready[0] = 1'b1;
      tick();
      arvalid[0] = 1'b0; arready[0] = 1'b0;
      rvalid[0] = 1'b1; set_rdata(0, 32'hA5A5A5A5);
      tick();
      chk("ch0_in_stall", 64'(dbg_state[1:0]), 64'h1);
      tick();
      tick();
      rready[0] = 1'b1;
      tick();
      rvalid[0] = 1'b0; rready[0] = 1'b0;
      tick();
      chk("clean_flags", 64'(err_flags), 64'h0);
      chk("clean_count", 64'(err_count), 64'h0);
      chk("clean_irq", 64'(err_irq), 64'h0);
      chk("clean_state", 64'(dbg_state[1:0]), 64'h0);

      // ch1 RDATA changes mid-stall
      arvalid[1] = 1'b1; arready[1] = 1'b1;
      tick();
      arvalid[1] = 1'b0; arready[1] = 1'b0;
      rvalid[1] = 1'b1; set_rdata(1, 32'h1);
      tick();
      tick();
      chk("rdata_no_err_yet", 64'(err_flags), 64'h0);
      set_rdata(1, 32'h2);
      tick();
      chk("rdata_flags", 64'(err_flags), 64'h40);
      chk("rdata_first_valid", 64'(first_valid), 64'h1);
      chk("rdata_first_ch", 64'(first_ch), 64'h1);
      chk("rdata_first_code", 64'(first_code), 64'h1);
      chk("rdata_irq", 64'(err_irq), 64'h1);
      chk("rdata_count", 64'(err_count), 64'h1);
      rready[1] = 1'b1;
      tick();
      rvalid[1] = 1'b0; rready[1] = 1'b0;
      tick();
      chk("rdata_count_once", 64'(err_count), 64'h1);
      clear_pulse();
      chk("clear_flags", 64'(err_flags), 64'h0);
      chk("clear_count", 64'(err_count), 64'h0);
      chk("clear_first_valid", 64'(first_valid), 64'h0);
      chk("clear_irq", 64'(err_irq), 64'h0);

      // ch2 RREADY held low 8 cycles: timeout once at the 6th edge
      arvalid[2] = 1'b1; arready[2] = 1'b1;
      tick();
      arvalid[2] = 1'b0; arready[2] = 1'b0;
      rvalid[2] = 1'b1; set_rdata(2, 32'h33);
      for (int i = 0; i < 5; i++) tick();
      chk("timeout_before_limit", 64'(err_count), 64'h0);
      chk("timeout_state_stall", 64'(dbg_state[5:4]), 64'h1);
      tick();
      chk("timeout_at_limit", 64'(err_count), 64'h1);
      chk("timeout_state", 64'(dbg_state[5:4]), 64'h2);
      tick();
      tick();
      rready[2] = 1'b1;
      tick();
      rvalid[2] = 1'b0; rready[2] = 1'b0;
      tick();
      chk("timeout_count_once", 64'(err_count), 64'h1);
      chk("timeout_flags", 64'(err_flags), 64'h8000);
      chk("timeout_first_ch", 64'(first_ch), 64'h2);
      chk("timeout_first_code", 64'(first_code), 64'h4);
      chk("timeout_back_idle", 64'(dbg_state[5:4]), 64'h0);
      clear_pulse();

      // ch3 R without AR, same edge as ch0 RVALID dropping mid-stall
      rvalid[0] = 1'b1; set_rdata(0, 32'h5);
      tick();
      tick();
      rvalid[0] = 1'b0;
      rvalid[3] = 1'b1; rready[3] = 1'b1;
      tick();
      rvalid[3] = 1'b0; rready[3] = 1'b0;
      chk("multi_count", 64'(err_count), 64'h2);
      chk("multi_first_ch", 64'(first_ch), 64'h0);
      chk("multi_first_code", 64'(first_code), 64'h2);
      chk("multi_flags", 64'(err_flags), 64'h400002);
      tick();
      chk("multi_count_hold", 64'(err_count), 64'h2);
      clear_pulse();

      // ch0 outstanding overflow, then clear racing a new overflow
      arvalid[0] = 1'b1; arready[0] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("ar_fill_no_err", 64'(err_count), 64'h0);
      tick();
      chk("overflow_flags", 64'(err_flags), 64'h20);
      chk("overflow_count", 64'(err_count), 64'h1);
      chk("overflow_first_code", 64'(first_code), 64'h6);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      arvalid[0] = 1'b0; arready[0] = 1'b0;
      chk("clear_vs_err_flags", 64'(err_flags), 64'h20);
      chk("clear_vs_err_count", 64'(err_count), 64'h1);
      chk("clear_vs_err_first_valid", 64'(first_valid), 64'h1);
      chk("clear_vs_err_first_code", 64'(first_code), 64'h6);

      // outstanding count survived the clear: 4 R ok, 5th has no AR
      rvalid[0] = 1'b1; rready[0] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("drain_no_err", 64'(err_count), 64'h1);
      tick();
      rvalid[0] = 1'b0; rready[0] = 1'b0;
      chk("drain_no_ar_count", 64'(err_count), 64'h2);
      chk("drain_no_ar_flags", 64'(err_flags), 64'h30);

      // AR and R on the same edge with counter 0 is legal
      arvalid[1] = 1'b1; arready[1] = 1'b1; rvalid[1] = 1'b1; rready[1] = 1'b1;
      tick();
      arvalid[1] = 1'b0; arready[1] = 1'b0; rvalid[1] = 1'b0; rready[1] = 1'b0;
      chk("ar_r_same_edge", 64'(err_count), 64'h2);

      // reset mid-stall: asynchronous clear, no error afterwards
      rvalid[2] = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      chk("async_rst_flags", 64'(err_flags), 64'h0);
      chk("async_rst_count", 64'(err_count), 64'h0);
      chk("async_rst_irq", 64'(err_irq), 64'h0);
      chk("async_rst_state", 64'(dbg_state), 64'h0);
      rvalid[2] = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_flags", 64'(err_flags), 64'h0);
      chk("post_rst_count", 64'(err_count), 64'h0);

      // RVALID high on the first edge after reset release
      rst_n = 1'b0;
      rvalid[2] = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rvalid_reset_flags", 64'(err_flags), 64'h4000);
      chk("rvalid_reset_count", 64'(err_count), 64'h1);
      chk("rvalid_reset_first_ch", 64'(first_ch), 64'h2);
      chk("rvalid_reset_first_code", 64'(first_code), 64'h3);
      chk("rvalid_reset_state", 64'(dbg_state), 64'h10);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
